// File: rtl/fu_shift_issue_if.sv
// Handshake bundle between the shift issue stage, its upstream producer and the
// shifter/consumer side. The DUT uses the slave view; the producer uses master.
interface fu_shift_issue_if #(parameter int TAG_W = 4);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [31:0]      a;
   logic [31:0]      b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      x;
   logic [4:0]       s;
   logic             left;
   logic             log;
   logic [TAG_W-1:0] out_tag;
   logic             out_clamp;

   modport master (
      output in_valid, op, a, b, in_tag, out_ready,
      input  in_ready, out_valid, x, s, left, log, out_tag, out_clamp
   );

   modport slave (
      input  in_valid, op, a, b, in_tag, out_ready,
      output in_ready, out_valid, x, s, left, log, out_tag, out_clamp
   );
endinterface

// File: rtl/fu_shift_issue.sv
// Issue stage ahead of the ShiftLR shifter: decodes/clamps shift ops at write time
// and holds them in a 2-entry FIFO whose head drives the shifter from registers.
module fu_shift_issue #(
   parameter int TAG_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   fu_shift_issue_if.slave io,
   output logic [15:0]     issue_cnt
);
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0]      x;
      logic [4:0]       s;
      logic             left;
      logic             log;
      logic [TAG_W-1:0] tag;
      logic             clamp;
   } entry_t;

   entry_t      slot_q [DEPTH];
   entry_t      slot_d [DEPTH];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic [15:0] issue_cnt_q, issue_cnt_d;
   logic        accept, pop, clamp;
   entry_t      new_entry;
   entry_t      head;

   assign io.in_ready  = (count_q != 2'(DEPTH));
   assign io.out_valid = (count_q != 2'd0);

   // Out-of-range amounts become a sign fill for SRA and a zero result otherwise.
   always_comb begin
      clamp           = |io.b[31:5];
      new_entry       = '0;
      new_entry.left  = io.op[1];
      new_entry.log   = io.op[0];
      new_entry.tag   = io.in_tag;
      new_entry.clamp = clamp;
      if (!clamp) begin
         new_entry.x = io.a;
         new_entry.s = io.b[4:0];
      end else if (io.op == 2'b00) begin
         new_entry.x = io.a;
         new_entry.s = 5'd31;
      end
   end

   always_comb begin
      accept      = io.in_valid && io.in_ready && !flush;
      pop         = io.out_valid && io.out_ready && !flush;
      slot_d      = slot_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      issue_cnt_d = issue_cnt_q;
      if (accept) begin
         slot_d[wr_ptr_q] = new_entry;
         wr_ptr_d         = ~wr_ptr_q;
         issue_cnt_d      = issue_cnt_q + 16'd1;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (accept && !pop) begin
         count_d = count_q + 2'd1;
      end else if (!accept && pop) begin
         count_d = count_q - 2'd1;
      end
      // Flush drops queued ops but leaves the issue counter running.
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         issue_cnt_q <= 16'd0;
      end else begin
         slot_q      <= slot_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   // Stale slots stay stored after a pop, so the head is masked when empty.
   assign head         = io.out_valid ? slot_q[rd_ptr_q] : '0;
   assign io.x         = head.x;
   assign io.s         = head.s;
   assign io.left      = head.left;
   assign io.log       = head.log;
   assign io.out_tag   = head.tag;
   assign io.out_clamp = head.clamp;
   assign issue_cnt    = issue_cnt_q;
endmodule

// File: tb/tb_fu_shift_issue.sv
// Scoreboard bench for fu_shift_issue: stimulus pushes expected entries computed
// from the shift rules; a negedge monitor pops and compares the presented head.
module tb_fu_shift_issue;
   localparam int TAG_W = 4;

   typedef struct {
      logic [31:0] x;
      logic [4:0]  s;
      logic [1:0]  lr;
      logic [3:0]  tag;
      logic        clamp;
      logic [31:0] z;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] issue_cnt;

   fu_shift_issue_if #(.TAG_W(TAG_W)) bus ();

   fu_shift_issue #(.TAG_W(TAG_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .io       (bus),
      .issue_cnt(issue_cnt)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   exp_t        exp_q[$];
   int          occ = 0;
   logic [15:0] exp_cnt = 16'd0;

   function automatic logic [31:0] gold_z(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      if (b >= 32'd32) begin
         return (op == 2'b00 && a[31]) ? 32'hFFFF_FFFF : 32'h0;
      end
      case (op)
         2'b00:   return 32'($signed(a) >>> b[4:0]);
         2'b01:   return a >> b[4:0];
         default: return a << b[4:0];
      endcase
   endfunction

   function automatic logic [31:0] shifter(logic [31:0] x, logic [4:0] s, logic left, logic log);
      if (left) return x << s;
      if (log)  return x >> s;
      return 32'($signed(x) >>> s);
   endfunction

   function automatic exp_t make_exp(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] tag);
      exp_t e;
      e.lr    = op;
      e.tag   = tag;
      e.clamp = (b > 32'd31);
      e.x     = a;
      e.s     = b[4:0];
      if (e.clamp) begin
         e.x = (op == 2'b00) ? a : 32'h0;
         e.s = (op == 2'b00) ? 5'd31 : 5'd0;
      end
      e.z = gold_z(op, a, b);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, "_out_valid"}, bus.out_valid, 1'b0);
      checkOutput({name, "_in_ready"}, bus.in_ready, 1'b1);
      checkOutput({name, "_fields"},
                  {bus.x, bus.s, bus.left, bus.log, bus.out_tag, bus.out_clamp}, 64'h0);
   endtask

   // Drives one cycle of inputs, updates the occupancy model at the edge, and
   // queues the expected head entry for every op the model says is accepted.
   task automatic applyStimulus(input bit iv, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] tag,
                                input bit ordy, input bit fl, output bit acc);
      bit pop;
      bus.in_valid  = iv;
      bus.op        = op;
      bus.a         = a;
      bus.b         = b;
      bus.in_tag    = tag;
      bus.out_ready = ordy;
      flush         = fl;
      @(posedge clk);
      acc = iv && (occ != 2) && !fl;
      pop = (occ != 0) && ordy && !fl;
      if (acc) begin
         exp_q.push_back(make_exp(op, a, b, tag));
         exp_cnt = exp_cnt + 16'd1;
      end
      occ = fl ? 0 : occ + int'(acc) - int'(pop);
      #1;
   endtask

   task automatic idle(input bit ordy);
      bit acc;
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 4'h0, ordy, 1'b0, acc);
   endtask

   function automatic logic [31:0] rand_b();
      return ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         checkOutput("in_ready", bus.in_ready, exp_q.size() != 2);
         checkOutput("out_valid", bus.out_valid, exp_q.size() != 0);
         checkOutput("issue_cnt", issue_cnt, exp_cnt);
         if (bus.out_valid && exp_q.size() != 0) begin
            e = exp_q[0];
            checkOutput("head_fields",
                        {bus.x, bus.s, bus.left, bus.log, bus.out_tag, bus.out_clamp},
                        {e.x, e.s, e.lr, e.tag, e.clamp});
            checkOutput("shift_z", shifter(bus.x, bus.s, bus.left, bus.log), e.z);
            if (bus.out_ready && !flush) void'(exp_q.pop_front());
         end else if (!bus.out_valid) begin
            checkOutput("idle_zero",
                        {bus.x, bus.s, bus.left, bus.log, bus.out_tag, bus.out_clamp}, 64'h0);
         end
         if (flush) exp_q.delete();
      end
   end

   initial begin
      bit          acc;
      int          tries;
      logic [15:0] cnt_before;
      bus.in_valid  = 1'b0;
      bus.op        = 2'b00;
      bus.a         = 32'h0;
      bus.b         = 32'h0;
      bus.in_tag    = 4'h0;
      bus.out_ready = 1'b0;

      #3;
      checkIdle("reset");
      checkOutput("reset_issue_cnt", issue_cnt, 16'h0);
      #9 rst_n = 1'b1;

      applyStimulus(1'b1, 2'b00, 32'h8000_0010, 32'd4, 4'd3, 1'b1, 1'b0, acc);
      checkOutput("single_valid", bus.out_valid, 1'b1);
      checkOutput("single_x", bus.x, 32'h8000_0010);
      checkOutput("single_s", bus.s, 5'd4);
      checkOutput("single_lr", {bus.left, bus.log}, 2'b00);
      checkOutput("single_tag", bus.out_tag, 4'd3);
      checkOutput("single_clamp", bus.out_clamp, 1'b0);
      checkOutput("single_z", shifter(bus.x, bus.s, bus.left, bus.log), 32'hF800_0001);
      checkOutput("single_cnt", issue_cnt, 16'd1);
      idle(1'b1);

      applyStimulus(1'b1, 2'b00, 32'h8000_0000, 32'd40, 4'd4, 1'b1, 1'b0, acc);
      checkOutput("clamp_sra_s", bus.s, 5'd31);
      checkOutput("clamp_sra_flag", bus.out_clamp, 1'b1);
      checkOutput("clamp_sra_z", shifter(bus.x, bus.s, bus.left, bus.log), 32'hFFFF_FFFF);
      idle(1'b1);
      applyStimulus(1'b1, 2'b11, 32'hFFFF_FFFF, 32'h1_0000, 4'd5, 1'b1, 1'b0, acc);
      checkOutput("clamp_sll_xs", {bus.x, bus.s}, 37'h0);
      checkOutput("clamp_sll_flag", bus.out_clamp, 1'b1);
      checkOutput("clamp_sll_z", shifter(bus.x, bus.s, bus.left, bus.log), 32'h0);
      idle(1'b1);

      applyStimulus(1'b1, 2'b01, 32'h1234_5678, 32'd1, 4'd1, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 2'b10, 32'h0000_00FF, 32'd8, 4'd2, 1'b0, 1'b0, acc);
      checkOutput("bp_in_ready_low", bus.in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 2'b00, 32'hF000_0000, 32'd2, 4'd3, 1'b0, 1'b0, acc);
         checkOutput("bp_head_held", bus.out_tag, 4'd1);
      end
      tries = 0;
      do begin
         applyStimulus(1'b1, 2'b00, 32'hF000_0000, 32'd2, 4'd3, 1'b1, 1'b0, acc);
         tries++;
      end while (!acc && tries < 8);
      checkOutput("bp_tag3_accepted", acc, 1'b1);
      repeat (3) idle(1'b1);
      checkOutput("bp_cnt", issue_cnt, 16'd6);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 2'($urandom), $urandom, rand_b(), 4'(i), 1'b1, 1'b0, acc);
         checkOutput("stream_valid", bus.out_valid, 1'b1);
      end
      idle(1'b1);
      checkOutput("stream_end", bus.out_valid, 1'b0);

      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, 2'($urandom), $urandom, rand_b(),
                       4'($urandom), $urandom_range(0, 2) != 0,
                       $urandom_range(0, 39) == 0, acc);
      end
      repeat (3) idle(1'b1);

      applyStimulus(1'b1, 2'b01, 32'hAAAA_5555, 32'd3, 4'd9, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 2'b11, 32'h0F0F_0F0F, 32'd4, 4'd10, 1'b0, 1'b0, acc);
      cnt_before = exp_cnt;
      applyStimulus(1'b1, 2'b10, 32'h1111_1111, 32'd5, 4'd11, 1'b1, 1'b1, acc);
      checkIdle("flush");
      checkOutput("flush_cnt", issue_cnt, cnt_before);

      tries = 0;
      while (exp_cnt != 16'hFFFF && tries < 70000) begin
         applyStimulus(1'b1, 2'($urandom), $urandom, rand_b(), 4'($urandom), 1'b1, 1'b0, acc);
         tries++;
      end
      checkOutput("wrap_preload", issue_cnt, 16'hFFFF);
      applyStimulus(1'b1, 2'b00, 32'h0000_0040, 32'd6, 4'd7, 1'b1, 1'b0, acc);
      checkOutput("wrap_zero", issue_cnt, 16'h0000);

      idle(1'b1);
      applyStimulus(1'b1, 2'b00, 32'h8765_4321, 32'd7, 4'd12, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 2'b01, 32'h8765_4321, 32'd9, 4'd13, 1'b0, 1'b0, acc);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkIdle("async_reset");
      checkOutput("async_reset_cnt", issue_cnt, 16'h0);
      exp_q.delete();
      occ     = 0;
      exp_cnt = 16'h0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      checkIdle("post_reset");

      applyStimulus(1'b1, 2'b10, 32'h0000_0003, 32'd30, 4'd14, 1'b1, 1'b0, acc);
      checkOutput("post_reset_z", shifter(bus.x, bus.s, bus.left, bus.log), 32'hC000_0000);
      repeat (2) idle(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
